// File: rtl/actor_token_receiver.sv
// Sink end of the actor token port: buffers up to MAX_TOKENS tokens, counts and checksums them.
// Optional protocol checking (sticky err) is enabled by ACTOR_TOKEN_RECEIVER_PROTOCOL_CHECK_EN.
module actor_token_receiver #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_TOKENS = 5,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] sink1_DATA,
   input  logic                  sink1_SEND,
   input  logic [15:0]           sink1_COUNT,
   output logic                  sink1_ACK,
   output logic                  sink1_RDY,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [15:0]           token_count,
   output logic [DATA_WIDTH-1:0] checksum,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StReady, StAck, StFull} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [15:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  accept;
   logic [DATA_WIDTH-1:0] mem [Depth];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         count_q  <= '0;
         sum_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         sum_q    <= sum_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      sum_d    = sum_q;
      accept   = 1'b0;
      unique case (state_q)
         StIdle:  state_d = StReady;
         StReady: begin
            if (sink1_SEND && !clear) begin
               accept   = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
               count_d  = count_q + 16'd1;
               sum_d    = sum_q + sink1_DATA;
               state_d  = StAck;
            end
         end
         StAck:   state_d = (count_q == 16'(MAX_TOKENS)) ? StFull : StReady;
         StFull:  state_d = StFull;
      endcase
      // clear wins over a simultaneous SEND; the token is dropped
      if (clear && state_q != StIdle) begin
         state_d  = StReady;
         wr_ptr_d = '0;
         count_d  = '0;
         sum_d    = '0;
      end
   end

   // Buffer is intentionally not reset
   always_ff @(posedge CLK) begin
      if (accept && !RESET) begin
         mem[wr_ptr_q] <= sink1_DATA;
      end
   end

   // Read-before-write: a same-cycle write to rd_addr returns the old word
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_data_q <= '0;
      end else if (32'(rd_addr) < MAX_TOKENS) begin
         rd_data_q <= mem[rd_addr];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign sink1_RDY   = (state_q == StReady);
   assign sink1_ACK   = (state_q == StAck);
   assign done        = (state_q == StFull);
   assign token_count = count_q;
   assign checksum    = sum_q;
   assign rd_data     = rd_data_q;

`ifdef ACTOR_TOKEN_RECEIVER_PROTOCOL_CHECK_EN
   logic err_q;
   logic proto_err;

   assign proto_err = sink1_SEND &&
                      ((state_q == StReady && sink1_COUNT != 16'd1) ||
                       state_q == StAck || state_q == StFull);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_q <= 1'b0;
      end else if (proto_err) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_count;
   assign unused_count = ^sink1_COUNT;
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_actor_token_receiver.sv
// Self-checking bench for actor_token_receiver: directed plan scenarios plus randomized traffic
// checked against a queue-based model of accepted tokens.
module tb_actor_token_receiver;

   localparam int unsigned DW = 8;
   localparam int unsigned MT = 5;
   localparam int unsigned AW = 3;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [DW-1:0] sink1_DATA;
   logic          sink1_SEND;
   logic [15:0]   sink1_COUNT;
   logic          sink1_ACK;
   logic          sink1_RDY;
   logic          clear;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [15:0]   token_count;
   logic [DW-1:0] checksum;
   logic          done;
   logic          err;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   // Model: tokens accepted since last reset/clear, last value written per address, sticky err
   logic [DW-1:0] acc_q[$];
   logic [DW-1:0] mem_m[8];
   bit            mem_v[8];
   bit            exp_err;

   actor_token_receiver #(
      .DATA_WIDTH(DW),
      .MAX_TOKENS(MT),
      .ADDR_WIDTH(AW)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .sink1_DATA(sink1_DATA),
      .sink1_SEND(sink1_SEND),
      .sink1_COUNT(sink1_COUNT),
      .sink1_ACK(sink1_ACK),
      .sink1_RDY(sink1_RDY),
      .clear(clear),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .token_count(token_count),
      .checksum(checksum),
      .done(done),
      .err(err)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] model_sum();
      int s = 0;
      foreach (acc_q[i]) s += int'(acc_q[i]);
      return DW'(s % 256);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      acc_q.delete();
      exp_err = 1'b0;
   endtask

   task automatic wait_rdy(output bit ok);
      int n = 0;
      while (sink1_RDY !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      ok = (sink1_RDY === 1'b1);
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_rdy: RDY=%b, required 1 within 8 cycles", sink1_RDY);
      end
   endtask

   task automatic send_token(input logic [DW-1:0] d, input logic [15:0] cnt);
      bit ok;
      wait_rdy(ok);
      if (!ok) return;
      sink1_DATA  = d;
      sink1_COUNT = cnt;
      sink1_SEND  = 1'b1;
      tick();
      sink1_SEND  = 1'b0;
      sink1_COUNT = 16'd1;
      mem_m[acc_q.size()] = d;
      mem_v[acc_q.size()] = 1'b1;
      acc_q.push_back(d);
`ifdef ACTOR_TOKEN_RECEIVER_PROTOCOL_CHECK_EN
      if (cnt != 16'd1) exp_err = 1'b1;
`endif
      n_cmp++; if (sink1_ACK !== 1'b1) begin n_fail++; $display("FAIL send_ack: ACK=%b req 1", sink1_ACK); end
      n_cmp++; if (sink1_RDY !== 1'b0) begin n_fail++; $display("FAIL send_rdy_low: RDY=%b req 0", sink1_RDY); end
      n_cmp++; if (token_count !== 16'(acc_q.size())) begin
         n_fail++; $display("FAIL send_count: got %0d req %0d", token_count, acc_q.size()); end
      n_cmp++; if (checksum !== model_sum()) begin
         n_fail++; $display("FAIL send_sum: got %h req %h", checksum, model_sum()); end
      n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL send_err: got %b req %b", err, exp_err); end
      tick();
      n_cmp++; if (sink1_ACK !== 1'b0) begin n_fail++; $display("FAIL ack_width: ACK=%b req 0", sink1_ACK); end
      n_cmp++; if (sink1_RDY !== (acc_q.size() < MT)) begin
         n_fail++; $display("FAIL post_rdy: RDY=%b req %b", sink1_RDY, acc_q.size() < MT); end
      n_cmp++; if (done !== (acc_q.size() == MT)) begin
         n_fail++; $display("FAIL post_done: done=%b req %b", done, acc_q.size() == MT); end
   endtask

   task automatic read_check(input int a);
      logic [DW-1:0] exp;
      rd_addr = AW'(a);
      tick();
      if (a >= MT) exp = '0;
      else if (mem_v[a]) exp = mem_m[a];
      else return;
      n_cmp++;
      if (rd_data !== exp) begin
         n_fail++;
         $display("FAIL read[%0d]: got %h req %h", a, rd_data, exp);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; sink1_SEND = 1'b0; clear = 1'b0; sink1_DATA = '0; sink1_COUNT = 16'd1;
      rd_addr = '0;
      tick();
      tick();
      model_reset();
      n_cmp++; if (sink1_RDY !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %b req 0", sink1_RDY); end
      n_cmp++; if (sink1_ACK !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b req 0", sink1_ACK); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b req 0", done); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b req 0", err); end
      n_cmp++; if (token_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d req 0", token_count); end
      n_cmp++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL rst_sum: got %h req 00", checksum); end
      n_cmp++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd: got %h req 00", rd_data); end
      RESET = 1'b0;
      tick();
      n_cmp++; if (sink1_RDY !== 1'b1) begin n_fail++; $display("FAIL rst_rdy_rise: got %b req 1", sink1_RDY); end
   endtask

   task automatic test_fill();
      logic [DW-1:0] toks[5] = '{8'h15, 8'h06, 8'h18, 8'h00, 8'h00};
      foreach (toks[i]) send_token(toks[i], 16'd1);
      n_cmp++; if (token_count !== 16'd5) begin n_fail++; $display("FAIL fill_count: got %0d req 5", token_count); end
      n_cmp++; if (checksum !== 8'h33) begin n_fail++; $display("FAIL fill_sum: got %h req 33", checksum); end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL fill_done: got %b req 1", done); end
      n_cmp++; if (sink1_RDY !== 1'b0) begin n_fail++; $display("FAIL fill_rdy: got %b req 0", sink1_RDY); end
      for (int a = 0; a < 5; a++) read_check(a);
      read_check(6);
   endtask

   task automatic test_send_when_full();
      sink1_DATA = 8'hAA;
      sink1_SEND = 1'b1;
      tick();
      sink1_SEND = 1'b0;
`ifdef ACTOR_TOKEN_RECEIVER_PROTOCOL_CHECK_EN
      exp_err = 1'b1;
`endif
      n_cmp++; if (sink1_ACK !== 1'b0) begin n_fail++; $display("FAIL full_ack: got %b req 0", sink1_ACK); end
      n_cmp++; if (token_count !== 16'd5) begin n_fail++; $display("FAIL full_count: got %0d req 5", token_count); end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b req 1", done); end
      tick();
      n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL full_err: got %b req %b", err, exp_err); end
      for (int a = 0; a < 5; a++) read_check(a);
   endtask

   task automatic test_wrap();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      acc_q.delete();
      n_cmp++; if (sink1_RDY !== 1'b1) begin n_fail++; $display("FAIL clr_rdy: got %b req 1", sink1_RDY); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL clr_done: got %b req 0", done); end
      n_cmp++; if (token_count !== 16'd0) begin n_fail++; $display("FAIL clr_count: got %0d req 0", token_count); end
      send_token(8'hF0, 16'd1);
      send_token(8'h20, 16'd1);
      n_cmp++; if (checksum !== 8'h10) begin n_fail++; $display("FAIL wrap_sum: got %h req 10", checksum); end
      n_cmp++; if (token_count !== 16'd2) begin n_fail++; $display("FAIL wrap_count: got %0d req 2", token_count); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got %b req 0", done); end
   endtask

   task automatic test_clear_with_send();
      bit ok;
      wait_rdy(ok);
      sink1_DATA = 8'h55;
      sink1_SEND = 1'b1;
      clear      = 1'b1;
      tick();
      sink1_SEND = 1'b0;
      clear      = 1'b0;
      acc_q.delete();
      n_cmp++; if (sink1_ACK !== 1'b0) begin n_fail++; $display("FAIL cws_ack: got %b req 0", sink1_ACK); end
      n_cmp++; if (token_count !== 16'd0) begin n_fail++; $display("FAIL cws_count: got %0d req 0", token_count); end
      n_cmp++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL cws_sum: got %h req 00", checksum); end
      n_cmp++; if (sink1_RDY !== 1'b1) begin n_fail++; $display("FAIL cws_rdy: got %b req 1", sink1_RDY); end
      send_token(8'h07, 16'd1);
      read_check(0);
   endtask

   task automatic test_reset_in_ack();
      bit ok;
      wait_rdy(ok);
      sink1_DATA = 8'h3C;
      sink1_SEND = 1'b1;
      tick();
      sink1_SEND = 1'b0;
      mem_m[acc_q.size()] = 8'h3C;
      mem_v[acc_q.size()] = 1'b1;
      n_cmp++; if (sink1_ACK !== 1'b1) begin n_fail++; $display("FAIL ria_ack: got %b req 1", sink1_ACK); end
      RESET = 1'b1;
      tick();
      model_reset();
      n_cmp++; if (sink1_ACK !== 1'b0) begin n_fail++; $display("FAIL ria_ack_low: got %b req 0", sink1_ACK); end
      n_cmp++; if (sink1_RDY !== 1'b0) begin n_fail++; $display("FAIL ria_rdy: got %b req 0", sink1_RDY); end
      n_cmp++; if (token_count !== 16'd0) begin n_fail++; $display("FAIL ria_count: got %0d req 0", token_count); end
      n_cmp++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL ria_sum: got %h req 00", checksum); end
      RESET = 1'b0;
      tick();
      n_cmp++; if (sink1_RDY !== 1'b1) begin n_fail++; $display("FAIL ria_rdy_rise: got %b req 1", sink1_RDY); end
   endtask

   task automatic test_count_err();
      send_token(8'h11, 16'd2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      acc_q.delete();
      n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL err_after_clear: got %b req %b", err, exp_err); end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      model_reset();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_after_reset: got %b req 0", err); end
      tick();
   endtask

   task automatic test_random();
      for (int it = 0; it < 80; it++) begin
         int r = int'($urandom_range(0, 11));
         if (r == 0) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            acc_q.delete();
            n_cmp++; if (token_count !== 16'd0 || sink1_RDY !== 1'b1) begin
               n_fail++; $display("FAIL rnd_clear: count=%0d rdy=%b req 0/1", token_count, sink1_RDY); end
         end else if (r <= 3) begin
            read_check(int'($urandom_range(0, 7)));
         end else if (acc_q.size() == MT) begin
            sink1_DATA = DW'($urandom);
            sink1_SEND = 1'b1;
            tick();
            sink1_SEND = 1'b0;
`ifdef ACTOR_TOKEN_RECEIVER_PROTOCOL_CHECK_EN
            exp_err = 1'b1;
`endif
            n_cmp++; if (sink1_ACK !== 1'b0 || token_count !== 16'(MT)) begin
               n_fail++; $display("FAIL rnd_full_send: ack=%b count=%0d req 0/%0d", sink1_ACK, token_count, MT); end
            tick();
            n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err: got %b req %b", err, exp_err); end
         end else begin
            int gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            send_token(DW'($urandom), 16'd1);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem_v[i] = 1'b0;
      test_reset();
      test_fill();
      test_send_when_full();
      test_wrap();
      test_clear_with_send();
      test_reset_in_ack();
      test_count_err();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
